// File: rtl/toggle_demux_router_pkg.sv
// rtl/toggle_demux_router_pkg.sv - state type and select/gap helpers for the toggle demux router
package toggle_demux_router_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROUTE    = 2'd1,
    S_WAIT_LOW = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam int DEF_GAP_CYCLES = 2;

  // Gap counter width is $clog2(GAP_CYCLES+1), kept at least 1 bit so GAP_CYCLES=0 still elaborates.
  function automatic int gap_cnt_width(input int gap_cycles);
    return (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
  endfunction

  function automatic logic sel_valid(input logic [31:0] sel, input int num_outputs);
    return sel < 32'(num_outputs);
  endfunction

endpackage

// File: rtl/toggle_demux_router_if.sv
// rtl/toggle_demux_router_if.sv - control/status bundle between the blinker side and the router
interface toggle_demux_router_if #(
  parameter int NUM_OUTPUTS    = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int EDGE_CNT_WIDTH = 8
);
  logic                      i_Enable;
  logic                      i_Toggle;
  logic [SEL_WIDTH-1:0]      i_Sel;
  logic [NUM_OUTPUTS-1:0]    o_Out;
  logic [SEL_WIDTH-1:0]      o_Active_Sel;
  logic                      o_Switching;
  logic [EDGE_CNT_WIDTH-1:0] o_Edge_Count;
  logic                      o_Sel_Err;

  modport master (
    output i_Enable, i_Toggle, i_Sel,
    input  o_Out, o_Active_Sel, o_Switching, o_Edge_Count, o_Sel_Err
  );

  modport slave (
    input  i_Enable, i_Toggle, i_Sel,
    output o_Out, o_Active_Sel, o_Switching, o_Edge_Count, o_Sel_Err
  );
endinterface

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - one-cycle pulse on a low-to-high transition of i_D
module edge_detect_rise (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Rise
);
  logic d_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) d_q <= 1'b0;
    else       d_q <= i_D;
  end

  assign o_Rise = i_D & ~d_q;
endmodule

// File: rtl/toggle_demux_router.sv
// rtl/toggle_demux_router.sv - routes the toggle waveform to one selected LED line with glitch-free hand-off
module toggle_demux_router
  import toggle_demux_router_pkg::*;
#(
  parameter int NUM_OUTPUTS    = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int EDGE_CNT_WIDTH = 8
) (
  input logic                   i_Clk,
  input logic                   i_Rst,
  toggle_demux_router_if.slave  rtr_if
);
  localparam int GAP_CNT_W = gap_cnt_width(GAP_CYCLES);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                    state_q, state_d;
  logic [SEL_WIDTH-1:0]      active_q, active_d;
  logic [SEL_WIDTH-1:0]      pending_q, pending_d;
  logic [GAP_CNT_W-1:0]      gap_q, gap_d;
  logic [EDGE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0]    out_q, out_d;
  logic                      switching_q, switching_d;
  logic                      sel_err_q;
  logic                      rise;
  logic                      sel_ok;
  logic                      routing;
  logic                      en;
  logic                      tog;
  logic [SEL_WIDTH-1:0]      sel;

  assign en  = rtr_if.i_Enable;
  assign tog = rtr_if.i_Toggle;
  assign sel = rtr_if.i_Sel;

  // History register runs in every state so the first routed edge is judged against the true previous level.
  edge_detect_rise u_rise (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_D    (tog),
    .o_Rise (rise)
  );

  assign sel_ok  = sel_valid(32'(sel), NUM_OUTPUTS);
  assign routing = (state_q == S_ROUTE) || (state_q == S_WAIT_LOW);

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;

    if (routing && rise) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (sel_ok) active_d = sel;
          state_d = S_ROUTE;
        end
      end
      S_ROUTE: begin
        if (sel_ok && (sel != active_q)) begin
          pending_d = sel;
          if (tog) begin
            state_d = S_WAIT_LOW;
          end else if (GAP_CYCLES == 0) begin
            active_d = pending_d;
            cnt_d    = '0;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_WAIT_LOW: begin
        if (sel_ok) pending_d = sel;
        if (sel == active_q) begin
          state_d = S_ROUTE;
        end else if (!tog) begin
          if (GAP_CYCLES == 0) begin
            state_d  = S_ROUTE;
            active_d = pending_d;
            cnt_d    = '0;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (sel_ok) pending_d = sel;
        if (gap_q == GAP_LAST) begin
          state_d  = S_ROUTE;
          active_d = pending_d;
          cnt_d    = '0;
          gap_d    = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable overrides whatever hand-off was being decided this cycle.
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end

    switching_d = (state_d == S_WAIT_LOW) || (state_d == S_GAP);
    out_d       = (en && routing && tog) ? (NUM_OUTPUTS'(1) << active_q) : '0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      pending_q   <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      switching_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      switching_q <= switching_d;
      sel_err_q   <= !sel_ok;
    end
  end

  assign rtr_if.o_Out        = out_q;
  assign rtr_if.o_Active_Sel = active_q;
  assign rtr_if.o_Switching  = switching_q;
  assign rtr_if.o_Edge_Count = cnt_q;
  assign rtr_if.o_Sel_Err    = sel_err_q;
endmodule

// File: tb/tb_toggle_demux_router.sv
// tb/tb_toggle_demux_router.sv - directed self-checking bench for toggle_demux_router
module tb_toggle_demux_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] prev_out = '0;

  toggle_demux_router_if #(.NUM_OUTPUTS(4), .SEL_WIDTH(3), .EDGE_CNT_WIDTH(8)) tif ();

  toggle_demux_router #(
    .NUM_OUTPUTS(4), .SEL_WIDTH(3), .GAP_CYCLES(2), .EDGE_CNT_WIDTH(8)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .rtr_if (tif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] o, input logic [2:0] a,
                            input logic sw, input logic [7:0] c);
    chk({tag, ".out"},   32'(tif.o_Out),        32'(o));
    chk({tag, ".act"},   32'(tif.o_Active_Sel), 32'(a));
    chk({tag, ".sw"},    32'(tif.o_Switching),  32'(sw));
    chk({tag, ".count"}, 32'(tif.o_Edge_Count), 32'(c));
  endtask

  task automatic step(input logic en, input logic tog, input logic [2:0] sel);
    tif.i_Enable = en;
    tif.i_Toggle = tog;
    tif.i_Sel    = sel;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    tests++;
    assert ($onehot0(tif.o_Out) && !((|(prev_out & ~tif.o_Out)) && (|(tif.o_Out & ~prev_out)))) else begin
      fails++;
      $error("FAIL onehot observed=%b prev=%b expected=onehot0 without overlap", tif.o_Out, prev_out);
    end
    prev_out = tif.o_Out;
  end

  initial begin
    tif.i_Enable = 1'b0;
    tif.i_Toggle = 1'b0;
    tif.i_Sel    = '0;

    step(0, 0, 0);
    step(0, 0, 0);
    expect_all("rst", 4'b0000, 3'd0, 1'b0, 8'd0);
    chk("rst.err", 32'(tif.o_Sel_Err), 32'd0);
    rst = 1'b0;
    step(0, 0, 0);
    expect_all("idle", 4'b0000, 3'd0, 1'b0, 8'd0);

    step(1, 0, 2);
    expect_all("t2_en", 4'b0000, 3'd2, 1'b0, 8'd0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        logic t;
        t = (i < 10);
        step(1, t, 2);
        chk("t2_out", 32'(tif.o_Out), t ? 32'h4 : 32'h0);
      end
    end
    expect_all("t2_cnt5", 4'b0000, 3'd2, 1'b0, 8'd5);

    step(1, 1, 2); expect_all("t3_hi",    4'b0100, 3'd2, 1'b0, 8'd6);
    step(1, 1, 1); expect_all("t3_wait",  4'b0100, 3'd2, 1'b1, 8'd6);
    step(1, 1, 1); expect_all("t3_hold",  4'b0100, 3'd2, 1'b1, 8'd6);
    step(1, 1, 1); expect_all("t3_hold",  4'b0100, 3'd2, 1'b1, 8'd6);
    step(1, 0, 1); expect_all("t3_gap1",  4'b0000, 3'd2, 1'b1, 8'd6);
    step(1, 0, 1); expect_all("t3_gap2",  4'b0000, 3'd2, 1'b1, 8'd6);
    step(1, 0, 1); expect_all("t3_new",   4'b0000, 3'd1, 1'b0, 8'd0);
    step(1, 1, 1); expect_all("t3_line1", 4'b0010, 3'd1, 1'b0, 8'd1);

    step(1, 1, 2); expect_all("t4_wait",   4'b0010, 3'd1, 1'b1, 8'd1);
    step(1, 1, 1); expect_all("t4_cancel", 4'b0010, 3'd1, 1'b0, 8'd1);
    step(1, 0, 1); expect_all("t4_low",    4'b0000, 3'd1, 1'b0, 8'd1);
    step(1, 1, 1); expect_all("t4_rise",   4'b0010, 3'd1, 1'b0, 8'd2);

    step(1, 1, 5); expect_all("t5_inv",  4'b0010, 3'd1, 1'b0, 8'd2);
    chk("t5_err1", 32'(tif.o_Sel_Err), 32'd1);
    step(1, 0, 5); expect_all("t5_inv2", 4'b0000, 3'd1, 1'b0, 8'd2);
    chk("t5_err2", 32'(tif.o_Sel_Err), 32'd1);
    step(1, 0, 1);
    chk("t5_err0", 32'(tif.o_Sel_Err), 32'd0);
    for (int k = 0; k < 253; k++) begin
      step(1, 1, 1);
      step(1, 0, 1);
    end
    expect_all("t5_255",  4'b0000, 3'd1, 1'b0, 8'd255);
    step(1, 1, 1); expect_all("t5_wrap", 4'b0010, 3'd1, 1'b0, 8'd0);

    step(1, 0, 1);
    step(1, 1, 1); expect_all("t6_pre",    4'b0010, 3'd1, 1'b0, 8'd1);
    step(1, 0, 0); expect_all("t6_gap",    4'b0000, 3'd1, 1'b1, 8'd1);
    step(0, 0, 2); expect_all("t6_off",    4'b0000, 3'd1, 1'b0, 8'd0);
    step(0, 1, 2); expect_all("t6_idle",   4'b0000, 3'd1, 1'b0, 8'd0);
    step(1, 1, 3); expect_all("t6_en",     4'b0000, 3'd3, 1'b0, 8'd0);
    step(1, 1, 3); expect_all("t6_norise", 4'b1000, 3'd3, 1'b0, 8'd0);
    step(1, 0, 3); expect_all("t6_low",    4'b0000, 3'd3, 1'b0, 8'd0);
    step(1, 1, 3); expect_all("t6_rise",   4'b1000, 3'd3, 1'b0, 8'd1);

    #2;
    rst = 1'b1;
    tif.i_Enable = 1'b0;
    tif.i_Toggle = 1'b1;
    #1;
    expect_all("t1_async", 4'b0000, 3'd0, 1'b0, 8'd0);
    #2;
    rst = 1'b0;
    step(0, 1, 2); expect_all("t1_idle",  4'b0000, 3'd0, 1'b0, 8'd0);
    step(1, 1, 2); expect_all("t1_en",    4'b0000, 3'd2, 1'b0, 8'd0);
    step(1, 1, 2); expect_all("t1_route", 4'b0100, 3'd2, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
